srama_port_ctrl: RTL



---
 rtl/srama_port_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/srama_port_ctrl.sv
// ---------------------------------------------------------------------------
// srama_port_ctrl
//
// Single-port SRAMA access controller. It sits between the ifmap feeder, the
// DMA write stream and the SRAMA macro.
//   - Feeder reads always own the port and go to the macro in the same cycle.
//   - DMA writes are held in a small circular FIFO. They drain on cycles
//     that have no read.
//   - A starvation flag tells the core to pause the feeder when buffered
//     writes have been blocked for too long.
//
// Optional feature macro: SRAMA_RAW_CHECK_EN
//   defined   : every read address is compared against all buffered write
//               addresses, including a write pushed in the same cycle. Any
//               match sets the sticky o_raw_hazard flag.
//   undefined : o_raw_hazard is tied to 0 and no comparators are built.
//
// Ports
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_clear        synchronous clear of buffer, counters and flags
//   i_rd_en        feeder read request
//   i_rd_addr      feeder read address
//   i_wr_valid     DMA write request
//   o_wr_ready     write buffer can accept a write (not full)
//   i_wr_addr      DMA write address
//   i_wr_data      DMA write data
//   i_wr_mask      DMA byte-enable mask
//   o_mem_cs       macro chip select
//   o_mem_we       macro write enable (1 = write)
//   o_mem_addr     macro address
//   o_mem_wdata    macro write data
//   o_mem_wmask    macro byte mask
//   o_rd_valid     macro read data valid, one cycle after the read issues
//   o_wbuf_count   number of buffered writes
//   o_wr_starve    buffered writes blocked for STARVE_LIM consecutive cycles
//   o_raw_hazard   sticky read-after-write hazard flag
// ---------------------------------------------------------------------------
module srama_port_ctrl #(
    parameter int ADRA_W     = 8,
    parameter int SRAMA_W    = 128,
    parameter int WBUF_DEPTH = 4,
    parameter int STARVE_LIM = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_clear,
    input  logic                            i_rd_en,
    input  logic [ADRA_W-1:0]               i_rd_addr,
    input  logic                            i_wr_valid,
    output logic                            o_wr_ready,
    input  logic [ADRA_W-1:0]               i_wr_addr,
    input  logic [SRAMA_W-1:0]              i_wr_data,
    input  logic [SRAMA_W/8-1:0]            i_wr_mask,
    output logic                            o_mem_cs,
    output logic                            o_mem_we,
    output logic [ADRA_W-1:0]               o_mem_addr,
    output logic [SRAMA_W-1:0]              o_mem_wdata,
    output logic [SRAMA_W/8-1:0]            o_mem_wmask,
    output logic                            o_rd_valid,
    output logic [$clog2(WBUF_DEPTH):0]     o_wbuf_count,
    output logic                            o_wr_starve,
    output logic                            o_raw_hazard
);

    localparam int MASK_W = SRAMA_W / 8;
    localparam int PTR_W  = $clog2(WBUF_DEPTH);
    localparam int STV_W  = $clog2(STARVE_LIM + 1);

    localparam logic [STV_W-1:0] STV_LOAD = STV_W'(STARVE_LIM);

    // Write buffer storage. Entries only need to hold valid data while
    // they are buffered, so the storage has no reset.
    logic [ADRA_W-1:0]  buf_addr [WBUF_DEPTH];
    logic [SRAMA_W-1:0] buf_data [WBUF_DEPTH];
    logic [MASK_W-1:0]  buf_mask [WBUF_DEPTH];

    // Pointers carry one extra MSB so that full and empty can be told apart.
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic             buf_empty;
    logic             buf_full;
    logic             push;
    logic             pop;

    logic [STV_W-1:0] stv_cnt;
    logic             rd_valid_q;

    assign wr_idx    = wr_ptr[PTR_W-1:0];
    assign rd_idx    = rd_ptr[PTR_W-1:0];
    assign buf_empty = (wr_ptr == rd_ptr);
    assign buf_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);

    // Ready follows registered state only. A pop in the same cycle does not
    // let a write into a full buffer.
    assign push = i_wr_valid && !buf_full;
    // A read owns the port. A clear cycle never issues a buffered write.
    assign pop  = !i_rd_en && !buf_empty && !i_clear;

    // -----------------------------------------------------------------------
    // Buffer pointers and storage
    // -----------------------------------------------------------------------
    // A write that arrives together with i_clear is dropped with the rest of
    // the buffer. The clear empties the buffer completely.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_addr[wr_idx] <= i_wr_addr;
            buf_data[wr_idx] <= i_wr_data;
            buf_mask[wr_idx] <= i_wr_mask;
        end
    end

    // -----------------------------------------------------------------------
    // Starvation timer
    // -----------------------------------------------------------------------
    // This is a down-counter that reloads to STARVE_LIM. It counts down on
    // each cycle where a read blocks a non-empty buffer, and it stops at
    // zero. A terminal count of zero is the same event as "blocked for
    // STARVE_LIM cycles".
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            stv_cnt <= STV_LOAD;
        end else if (pop || buf_empty) begin
            stv_cnt <= STV_LOAD;
        end else if (i_rd_en && (stv_cnt != '0)) begin
            stv_cnt <= stv_cnt - STV_W'(1);
        end
    end

    assign o_wr_starve = (stv_cnt == '0);

    // -----------------------------------------------------------------------
    // Read valid, aligned with the one-cycle macro read latency
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= i_rd_en;
        end
    end

    assign o_rd_valid   = rd_valid_q;
    assign o_wr_ready   = !buf_full;
    assign o_wbuf_count = wr_ptr - rd_ptr;

    // -----------------------------------------------------------------------
    // Port arbitration. It is combinational so feeder reads see no extra
    // latency.
    // -----------------------------------------------------------------------
    always_comb begin
        o_mem_cs    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_wmask = '0;
        if (i_rd_en) begin
            o_mem_cs   = 1'b1;
            o_mem_addr = i_rd_addr;
        end else if (pop) begin
            o_mem_cs    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = buf_addr[rd_idx];
            o_mem_wdata = buf_data[rd_idx];
            o_mem_wmask = buf_mask[rd_idx];
        end
    end

    // -----------------------------------------------------------------------
    // Read-after-write hazard detection
    // -----------------------------------------------------------------------
`ifdef SRAMA_RAW_CHECK_EN
    logic [WBUF_DEPTH-1:0] ent_vld;
    logic                  raw_hit;
    logic                  raw_q;

    // Per-entry valid bits. Only occupied slots take part in the compare.
    // Push and pop never target the same slot in one cycle: push needs
    // !full and pop needs !empty, so the two indices differ whenever both
    // happen.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            ent_vld <= '0;
        end else begin
            if (pop) begin
                ent_vld[rd_idx] <= 1'b0;
            end
            if (push) begin
                ent_vld[wr_idx] <= 1'b1;
            end
        end
    end

    // A write entering the buffer in this cycle is also still unwritten
    // when the read returns, so it counts as a hazard too.
    always_comb begin
        raw_hit = 1'b0;
        if (i_rd_en) begin
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                if (ent_vld[i] && (buf_addr[i] == i_rd_addr)) begin
                    raw_hit = 1'b1;
                end
            end
            if (push && (i_wr_addr == i_rd_addr)) begin
                raw_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            raw_q <= 1'b0;
        end else if (raw_hit) begin
            raw_q <= 1'b1;
        end
    end

    assign o_raw_hazard = raw_q;
`else
    assign o_raw_hazard = 1'b0;
`endif

endmodule
